// File: rtl/boreal_boot_ctrl.sv
// Secure boot sequencer: waits for the boot ROM verdict, retries failed
// attempts by pulsing the boot ROM reset, releases the CPU after a fixed
// delay on a pass, and locks down once the retry allowance is used up.
// A small register bank exposes status, the measured hash and the timer.
module boreal_boot_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned RELEASE_DELAY  = 16,
    parameter int unsigned RETRY_HOLD     = 8,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_done,
    input  logic        boot_pass,
    input  logic [31:0] boot_hash,
    output logic        bootrom_rst_n,
    output logic        cpu_rst_n,
    output logic        lockdown,
    output logic        fail_irq,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack
);

    typedef enum logic [2:0] {
        S_WAIT_BOOT = 3'd0,
        S_RETRY     = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_LOCKED    = 3'd4
    } state_t;

    // Terminal counts for the per-state counters.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_DELAY);
    localparam logic [7:0]  HOLD_LAST    = 8'(RETRY_HOLD);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

    state_t      state_reg;
    logic [31:0] timer_reg;
    logic [3:0]  retry_cnt_reg;
    logic [31:0] hash_reg;
    logic        pass_flag_reg;
    logic [15:0] dly_cnt_reg;
    logic [7:0]  hold_cnt_reg;
    logic        cpu_rst_n_reg;
    logic        bootrom_rst_n_reg;
    logic        lockdown_reg;
    logic        fail_irq_reg;
    logic [31:0] rdata_reg;
    logic        ack_reg;

    logic        attempt_pass;
    logic        attempt_fail;
    logic        lock_entry;
    logic        ctrl_clear;
    logic [31:0] read_data;
    logic        unused_bits;

    // A completed boot always wins over a coincident timeout.
    assign attempt_pass = (state_reg == S_WAIT_BOOT) && boot_done && boot_pass;
    assign attempt_fail = (state_reg == S_WAIT_BOOT) &&
                          (boot_done ? !boot_pass : (timer_reg == TIMEOUT_LAST));
    assign lock_entry   = attempt_fail && (retry_cnt_reg >= RETRY_MAX);
    assign ctrl_clear   = sel && we && (addr[3:2] == 2'd3) && wdata[0];

    // Only addr[3:2] and wdata[0] carry meaning.
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:1]};

    // Boot sequencing FSM with its timers and registered reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= S_WAIT_BOOT;
            timer_reg         <= 32'd0;
            retry_cnt_reg     <= 4'd0;
            hash_reg          <= 32'd0;
            pass_flag_reg     <= 1'b0;
            dly_cnt_reg       <= 16'd0;
            hold_cnt_reg      <= 8'd0;
            cpu_rst_n_reg     <= 1'b0;
            bootrom_rst_n_reg <= 1'b1;
            lockdown_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_WAIT_BOOT: begin
                    timer_reg <= timer_reg + 32'd1;
                    if (attempt_pass) begin
                        hash_reg      <= boot_hash;
                        pass_flag_reg <= 1'b1;
                        dly_cnt_reg   <= 16'd0;
                        state_reg     <= S_RELEASE;
                    end else if (attempt_fail) begin
                        if (lock_entry) begin
                            lockdown_reg <= 1'b1;
                            state_reg    <= S_LOCKED;
                        end else begin
                            retry_cnt_reg <= retry_cnt_reg + 4'd1;
                            hold_cnt_reg  <= 8'd0;
                            state_reg     <= S_RETRY;
                        end
                    end
                end
                S_RETRY: begin
                    // The boot ROM reset drops one cycle after the failing
                    // edge and stays low for HOLD_LAST cycles.
                    if (hold_cnt_reg == HOLD_LAST) begin
                        bootrom_rst_n_reg <= 1'b1;
                        timer_reg         <= 32'd0;
                        state_reg         <= S_WAIT_BOOT;
                    end else begin
                        bootrom_rst_n_reg <= 1'b0;
                        hold_cnt_reg      <= hold_cnt_reg + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (dly_cnt_reg == RELEASE_LAST) begin
                        cpu_rst_n_reg <= 1'b1;
                        state_reg     <= S_RUN;
                    end else begin
                        dly_cnt_reg <= dly_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    // RUN and LOCKED hold until the next reset.
                end
            endcase
        end
    end

    // Sticky failure interrupt; a lockdown on the same edge beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_irq_reg <= 1'b0;
        end else if (lock_entry) begin
            fail_irq_reg <= 1'b1;
        end else if (ctrl_clear) begin
            fail_irq_reg <= 1'b0;
        end
    end

    // Register read decode. STATUS packs the state at [11:9], the retry
    // count at [8:5], a reserved zero at [4] and the flags at [3:0].
    always_comb begin
        read_data = 32'd0;
        case (addr[3:2])
            2'd0: read_data = {20'd0, state_reg, retry_cnt_reg, 1'b0,
                               fail_irq_reg, lockdown_reg, cpu_rst_n_reg, pass_flag_reg};
            2'd1: read_data = hash_reg;
            2'd2: read_data = timer_reg;
            default: read_data = 32'd0;
        endcase
    end

    // Bus response: one-cycle acknowledge, read data zero when not selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            ack_reg   <= sel;
            rdata_reg <= sel ? read_data : 32'd0;
        end
    end

    assign bootrom_rst_n = bootrom_rst_n_reg;
    assign cpu_rst_n     = cpu_rst_n_reg;
    assign lockdown      = lockdown_reg;
    assign fail_irq      = fail_irq_reg;
    assign rdata         = rdata_reg;
    assign ack           = ack_reg;

endmodule

// File: tb/tb_boreal_boot_ctrl.sv
// Bench for boreal_boot_ctrl: an event-time model (absolute edge numbers
// for pass, failure and re-entry) predicts every output each cycle, and
// directed scenarios pin key timings with hand-computed literals.
module tb_boreal_boot_ctrl;

    localparam int TO = 64;
    localparam int RD = 4;
    localparam int RH = 3;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        boot_done = 1'b0;
    logic        boot_pass = 1'b0;
    logic [31:0] boot_hash = 32'd0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        bootrom_rst_n, cpu_rst_n, lockdown, fail_irq, ack;
    logic [31:0] rdata;

    int n_vec = 0;
    int n_err = 0;

    boreal_boot_ctrl #(
        .TIMEOUT_CYCLES(TO), .RELEASE_DELAY(RD), .RETRY_HOLD(RH), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .boot_done(boot_done), .boot_pass(boot_pass),
        .boot_hash(boot_hash), .bootrom_rst_n(bootrom_rst_n), .cpu_rst_n(cpu_rst_n),
        .lockdown(lockdown), .fail_irq(fail_irq), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // n: edges since reset release. Phases use the state numbering
    // 0 wait, 1 retry, 2 release, 3 run, 4 locked.
    int n, att_start, fail_edge, pass_edge, m_phase, m_retry;
    logic [31:0] m_frozen, m_hash, m_rdata;
    logic m_pass, m_cpu, m_boot, m_lock, m_irq, m_ack;

    function automatic logic [31:0] m_timer();
        return (m_phase == 0) ? 32'(n - att_start) : m_frozen;
    endfunction

    task automatic model_reset();
        n = 0; att_start = 0; fail_edge = 0; pass_edge = 0; m_phase = 0; m_retry = 0;
        m_frozen = 0; m_hash = 0; m_rdata = 0;
        m_pass = 0; m_cpu = 0; m_boot = 1; m_lock = 0; m_irq = 0; m_ack = 0;
    endtask

    task automatic model_edge();
        int e;
        logic [31:0] t;
        logic set_irq;
        e = n + 1;
        t = m_timer();
        set_irq = 1'b0;
        m_ack = sel;
        m_rdata = 32'd0;
        if (sel) begin
            if (addr[3:2] == 2'd0)
                m_rdata = {20'd0, 3'(m_phase), 4'(m_retry), 1'b0, m_irq, m_lock, m_cpu, m_pass};
            else if (addr[3:2] == 2'd1)
                m_rdata = m_hash;
            else if (addr[3:2] == 2'd2)
                m_rdata = t;
        end
        if (m_phase == 0) begin
            if (boot_done && boot_pass) begin
                m_hash = boot_hash; m_pass = 1; pass_edge = e; m_frozen = t + 1; m_phase = 2;
            end else if (boot_done || t == 32'(TO - 1)) begin
                m_frozen = t + 1;
                if (m_retry < MR) begin
                    m_retry++; fail_edge = e; m_phase = 1;
                end else begin
                    m_phase = 4; m_lock = 1; set_irq = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (e == fail_edge + RH + 1) begin
                m_phase = 0; att_start = e; m_boot = 1;
            end else begin
                m_boot = 0;
            end
        end else if (m_phase == 2) begin
            if (e == pass_edge + RD + 1) begin
                m_phase = 3; m_cpu = 1;
            end
        end
        if (set_irq) m_irq = 1;
        else if (sel && we && addr[3:2] == 2'd3 && wdata[0]) m_irq = 0;
        n = e;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("bootrom_rst_n", 32'(bootrom_rst_n), 32'(m_boot));
            chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
            chk("lockdown", 32'(lockdown), 32'(m_lock));
            chk("fail_irq", 32'(fail_irq), 32'(m_irq));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("rdata", rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Return at the negedge before edge k so new inputs are sampled at edge k.
    task automatic goto_edge(input int k);
        int guard;
        guard = 0;
        while (n < k - 1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Edge number at which the chosen output first shows val; -1 if never.
    task automatic wait_out(input int which, input logic val, input int limit, output int edge_no);
        logic cur;
        edge_no = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cur = (which == 0) ? cpu_rst_n : (which == 1) ? bootrom_rst_n : lockdown;
            if (cur === val) begin
                edge_no = n;
                break;
            end
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel = 1; we = 0; addr = a;
        @(negedge clk);
        d = rdata;
        sel = 0; addr = 0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        @(negedge clk);
        sel = 0; we = 0; addr = 0; wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rst_bootrom", 32'(bootrom_rst_n), 32'd1);
        chk("rst_lockdown", 32'(lockdown), 32'd0);
        chk("rst_irq", 32'(fail_irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic apply_pass(input int k, input logic [31:0] h);
        goto_edge(k);
        boot_done = 1; boot_pass = 1; boot_hash = h;
        @(negedge clk);
        boot_done = 0; boot_pass = 0; boot_hash = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int e;
        logic [31:0] d;
        #1 rst_n = 0;

        // Pass path.
        do_reset();
        apply_pass(10, 32'hDEADBEEF);
        wait_out(0, 1'b1, 100, e);
        chk("pass_cpu_rise_edge", 32'(e), 32'd15);
        for (int i = 0; i < 6; i++) begin
            boot_done = i[0]; boot_pass = 1; boot_hash = 32'h0BAD0000 + 32'(i);
            @(negedge clk);
        end
        boot_done = 0; boot_pass = 0; boot_hash = 0;
        chk("run_cpu_hold", 32'(cpu_rst_n), 32'd1);
        bus_read(32'h4, d);
        chk("hash_read", d, 32'hDEADBEEF);
        bus_read(32'h0, d);
        chk("status_state_run", 32'(d[11:9]), 32'd3);
        chk("status_flags_run", 32'(d[3:0]), 32'h3);
        bus_read(32'hC, d);
        chk("ctrl_reads_zero", d, 32'd0);
        bus_write(32'h0, 32'hFFFFFFFF);
        bus_write(32'h4, 32'h12345678);
        bus_read(32'h4, d);
        chk("hash_write_ignored", d, 32'hDEADBEEF);

        // Signature fail, then pass.
        do_reset();
        goto_edge(10);
        boot_done = 1; boot_pass = 0; boot_hash = 32'h11111111;
        @(negedge clk);
        boot_done = 0;
        wait_out(1, 1'b0, 20, e);
        chk("retry_low_first", 32'(e), 32'd11);
        wait_out(1, 1'b1, 20, e);
        chk("retry_low_last", 32'(e - 1), 32'd13);
        apply_pass(20, 32'h12345678);
        wait_out(0, 1'b1, 100, e);
        chk("retry_pass_cpu_rise", 32'(e), 32'd25);
        bus_read(32'h0, d);
        chk("status_retry_cnt", 32'(d[8:5]), 32'd1);
        chk("status_state_run2", 32'(d[11:9]), 32'd3);

        // Three consecutive signature failures.
        do_reset();
        boot_done = 1; boot_pass = 0;
        wait_out(2, 1'b1, 200, e);
        boot_done = 0;
        chk("sigfail_lock_edge", 32'(e), 32'd11);
        chk("sigfail_irq", 32'(fail_irq), 32'd1);
        chk("sigfail_cpu", 32'(cpu_rst_n), 32'd0);
        bus_read(32'h0, d);
        chk("status_locked", 32'(d[11:5]), 32'h42);
        bus_write(32'hC, 32'h1);
        chk("irq_cleared", 32'(fail_irq), 32'd0);
        chk("lock_kept", 32'(lockdown), 32'd1);

        // Timeouts only.
        do_reset();
        wait_out(2, 1'b1, 400, e);
        chk("timeout_lock_edge", 32'(e), 32'd200);
        bus_read(32'h8, d);
        chk("timer_frozen", d, 32'd64);

        // Pass coincident with timeout.
        do_reset();
        apply_pass(64, 32'hCAFEF00D);
        wait_out(0, 1'b1, 100, e);
        chk("edge_pass_cpu_rise", 32'(e), 32'd69);

        // Reset pulse in the middle of RELEASE, then a clean rerun.
        do_reset();
        apply_pass(10, 32'hA5A5A5A5);
        goto_edge(13);
        do_reset();
        apply_pass(10, 32'h5A5A5A5A);
        wait_out(0, 1'b1, 100, e);
        chk("rerun_cpu_rise", 32'(e), 32'd15);
        bus_read(32'h0, d);
        chk("rerun_retry_zero", 32'(d[8:5]), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
